// File: rtl/iter_shifter.sv
// Multi-cycle shift/rotate unit: shifts a WIDTH-bit operand by amt in steps of up to STEP bits
// per clock. Six modes (pass, LSL, LSR, ASR, ROL, ROR), with result, carry-out and zero flag.
module iter_shifter #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sout,
    output logic             carry,
    output logic             zero,
    output logic [1:0]       dbg_state
);

    // Handshake: start is taken on a rising edge where ready=1 (IDLE or DONE). Operands are
    // sampled on that edge only. done is high for exactly one cycle, and sout/carry/zero are
    // valid from then until the next done.

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [2:0] M_LSL = 3'b001;
    localparam logic [2:0] M_LSR = 3'b010;
    localparam logic [2:0] M_ASR = 3'b011;
    localparam logic [2:0] M_ROL = 3'b100;
    localparam logic [2:0] M_ROR = 3'b101;

    localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

    logic [1:0]         state;
    logic [WIDTH-1:0]   work;
    logic [AMT_W-1:0]   rem;
    logic [2:0]         op;
    logic [AMT_W-1:0]   k;
    logic [2*WIDTH-1:0] wide;
    logic [WIDTH-1:0]   shifted;
    logic               cout;
    logic               no_shift;

    assign k        = (rem < STEP_A) ? rem : STEP_A;
    assign no_shift = (amt == '0) || (mode == 3'b000) || (mode[2:1] == 2'b11);

    // Shifting in a double-width vector keeps the last departing bit at a fixed position.
    always_comb begin
        wide    = '0;
        shifted = work;
        cout    = 1'b0;
        case (op)
            M_LSL: begin
                wide    = {{WIDTH{1'b0}}, work} << k;
                shifted = wide[WIDTH-1:0];
                cout    = wide[WIDTH];
            end
            M_LSR: begin
                wide    = {work, {WIDTH{1'b0}}} >> k;
                shifted = wide[2*WIDTH-1:WIDTH];
                cout    = wide[WIDTH-1];
            end
            M_ASR: begin
                wide    = $unsigned($signed({work, {WIDTH{1'b0}}}) >>> k);
                shifted = wide[2*WIDTH-1:WIDTH];
                cout    = wide[WIDTH-1];
            end
            M_ROL: begin
                wide    = {work, work} << k;
                shifted = wide[2*WIDTH-1:WIDTH];
                cout    = shifted[0];
            end
            M_ROR: begin
                wide    = {work, work} >> k;
                shifted = wide[WIDTH-1:0];
                cout    = shifted[WIDTH-1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            work  <= '0;
            rem   <= '0;
            op    <= '0;
            sout  <= '0;
            carry <= 1'b0;
            zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        work <= in;
                        rem  <= amt;
                        op   <= mode;
                        if (no_shift) begin
                            sout  <= in;
                            carry <= 1'b0;
                            zero  <= (in == '0);
                            state <= S_DONE;
                        end else begin
                            state <= S_SHIFT;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    work <= shifted;
                    rem  <= rem - k;
                    if (rem == k) begin
                        sout  <= shifted;
                        carry <= cout;
                        zero  <= (shifted == '0);
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ready     = (state == S_IDLE) || (state == S_DONE);
    assign busy      = (state == S_SHIFT);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter: STEP=1 and STEP=4 instances checked every cycle against an
// arithmetic reference with latency countdown, plus directed vectors with literal results.
module tb_iter_shifter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  start_v;
    logic [2:0]  mode_v [2];
    logic [3:0]  amt_v  [2];
    logic [15:0] in_v   [2];
    logic [1:0]  ready_v, busy_v, done_v, carry_v, zero_v;
    logic [15:0] sout_v [2];
    logic [1:0]  dbg_v  [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    iter_shifter #(.WIDTH(16), .AMT_W(4), .STEP(1)) u_s1 (
        .clk(clk), .reset(reset), .start(start_v[0]), .mode(mode_v[0]), .amt(amt_v[0]),
        .in(in_v[0]), .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .sout(sout_v[0]), .carry(carry_v[0]), .zero(zero_v[0]), .dbg_state(dbg_v[0])
    );

    iter_shifter #(.WIDTH(16), .AMT_W(4), .STEP(4)) u_s4 (
        .clk(clk), .reset(reset), .start(start_v[1]), .mode(mode_v[1]), .amt(amt_v[1]),
        .in(in_v[1]), .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .sout(sout_v[1]), .carry(carry_v[1]), .zero(zero_v[1]), .dbg_state(dbg_v[1])
    );

    // Full-amount result computed in one go; returns {carry, result}.
    function automatic logic [16:0] ref_op(input logic [15:0] x, input logic [2:0] m,
                                           input logic [3:0] a);
        logic [15:0] r;
        logic        c;
        logic [31:0] t;
        int          n;
        n = int'(a);
        r = x;
        c = 1'b0;
        t = {16'h0000, x};
        if (n != 0) begin
            case (m)
                3'd1: begin t = t << n; r = t[15:0]; c = t[16]; end
                3'd2: begin r = x >> n; t = t >> (n - 1); c = t[0]; end
                3'd3: begin r = $signed(x) >>> n; t = t >> (n - 1); c = t[0]; end
                3'd4: begin r = (x << n) | (x >> (16 - n)); c = r[0]; end
                3'd5: begin r = (x >> n) | (x << (16 - n)); c = r[15]; end
                default: ;
            endcase
        end
        return {c, r};
    endfunction

    function automatic int lat_of(input logic [2:0] m, input logic [3:0] a, input int s);
        if (a == 4'd0 || m == 3'd0 || m > 3'd5) return 1;
        return 1 + (int'(a) + s - 1) / s;
    endfunction

    // Reference model: 0 idle, 1 busy (m_cnt edges left), 2 done.
    int          m_state [2];
    int          m_cnt   [2];
    logic [16:0] m_pend  [2];
    logic [15:0] m_sout  [2];
    logic        m_carry [2];
    logic        m_zero  [2];
    logic [16:0] cand    [2];
    int          cand_lat[2];

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            cand[d]     = ref_op(in_v[d], mode_v[d], amt_v[d]);
            cand_lat[d] = lat_of(mode_v[d], amt_v[d], (d == 0) ? 1 : 4);
        end
    end

    always @(posedge clk or posedge reset) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_state[d] <= 0;
                m_cnt[d]   <= 0;
                m_pend[d]  <= '0;
                m_sout[d]  <= '0;
                m_carry[d] <= 1'b0;
                m_zero[d]  <= 1'b0;
            end else if (m_state[d] == 1) begin
                m_cnt[d] <= m_cnt[d] - 1;
                if (m_cnt[d] == 1) begin
                    m_state[d] <= 2;
                    m_sout[d]  <= m_pend[d][15:0];
                    m_carry[d] <= m_pend[d][16];
                    m_zero[d]  <= (m_pend[d][15:0] == 16'h0000);
                end
            end else if (start_v[d]) begin
                if (cand_lat[d] == 1) begin
                    m_state[d] <= 2;
                    m_sout[d]  <= cand[d][15:0];
                    m_carry[d] <= cand[d][16];
                    m_zero[d]  <= (cand[d][15:0] == 16'h0000);
                end else begin
                    m_state[d] <= 1;
                    m_cnt[d]   <= cand_lat[d] - 1;
                    m_pend[d]  <= cand[d];
                end
            end else begin
                m_state[d] <= 0;
            end
        end
    end

    task automatic check(input int d, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (step%0d): got %0h expected %0h", name, (d == 0) ? 1 : 4, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check(d, "ready", ready_v[d], m_state[d] != 1);
            check(d, "busy", busy_v[d], m_state[d] == 1);
            check(d, "done", done_v[d], m_state[d] == 2);
            check(d, "sout", sout_v[d], m_sout[d]);
            check(d, "carry", carry_v[d], m_carry[d]);
            check(d, "zero", zero_v[d], m_zero[d]);
        end
    end

    // One operation with literal expectations; optionally pokes start while busy.
    task automatic run_lit(input int d, input string name, input logic [15:0] x,
                           input logic [2:0] m, input logic [3:0] a, input logic [15:0] e_sout,
                           input logic e_carry, input logic e_zero, input int e_lat,
                           input bit poke);
        int edges;
        @(negedge clk);
        in_v[d]    = x;
        mode_v[d]  = m;
        amt_v[d]   = a;
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
        edges = 1;
        while (done_v[d] !== 1'b1 && edges < 100) begin
            if (poke && edges == 1) begin
                start_v[d] = 1'b1;
                in_v[d]    = 16'hFFFF;
                mode_v[d]  = 3'b001;
                amt_v[d]   = 4'd3;
            end
            @(negedge clk);
            edges++;
            start_v[d] = 1'b0;
        end
        check(d, {name, " latency"}, edges, e_lat);
        check(d, {name, " sout"}, sout_v[d], e_sout);
        check(d, {name, " carry"}, carry_v[d], e_carry);
        check(d, {name, " zero"}, zero_v[d], e_zero);
    endtask

    initial begin
        int edges;
        int dcount;
        start_v = '0;
        for (int d = 0; d < 2; d++) begin
            mode_v[d] = '0;
            amt_v[d]  = '0;
            in_v[d]   = '0;
        end
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        check(0, "reset ready", ready_v[0], 1);
        check(1, "reset ready", ready_v[1], 1);
        check(0, "reset sout", sout_v[0], 0);
        reset = 1'b0;

        run_lit(0, "lsl1", 16'h8001, 3'd1, 4'd1, 16'h0002, 1'b1, 1'b0, 2, 1'b0);

        // Reset in the middle of a long shift: nothing from it may surface.
        @(negedge clk);
        in_v[0] = 16'h00FF; mode_v[0] = 3'd1; amt_v[0] = 4'd9; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        check(0, "pre-reset busy", busy_v[0], 1);
        #2 reset = 1'b1;
        #1;
        check(0, "async reset ready", ready_v[0], 1);
        check(0, "async reset sout", sout_v[0], 0);
        check(0, "async reset busy", busy_v[0], 0);
        check(0, "async reset done", done_v[0], 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_v[0] === 1'b1) dcount++;
        end
        check(0, "no done after reset", dcount, 0);

        run_lit(0, "asr15", 16'h8000, 3'd3, 4'd15, 16'hFFFF, 1'b0, 1'b0, 16, 1'b1);
        run_lit(0, "lsr1", 16'h0001, 3'd2, 4'd1, 16'h0000, 1'b1, 1'b1, 2, 1'b1);
        run_lit(0, "pass110", 16'hBEEF, 3'b110, 4'd5, 16'hBEEF, 1'b0, 1'b0, 1, 1'b0);
        run_lit(0, "rol2", 16'hC000, 3'd4, 4'd2, 16'h0003, 1'b1, 1'b0, 3, 1'b0);
        run_lit(1, "ror8", 16'h1234, 3'd5, 4'd8, 16'h3412, 1'b0, 1'b0, 3, 1'b0);
        run_lit(1, "amt0", 16'h1234, 3'd5, 4'd0, 16'h1234, 1'b0, 1'b0, 1, 1'b0);
        run_lit(1, "lsl6", 16'h0F0F, 3'd1, 4'd6, 16'hC3C0, 1'b1, 1'b0, 3, 1'b0);
        run_lit(1, "asr6", 16'h8421, 3'd3, 4'd6, 16'hFE10, 1'b1, 1'b0, 3, 1'b0);

        // Back-to-back: start held high, second op taken in the DONE cycle.
        @(negedge clk);
        in_v[0] = 16'h00F0; mode_v[0] = 3'd2; amt_v[0] = 4'd4; start_v[0] = 1'b1;
        @(negedge clk);
        edges = 1;
        while (done_v[0] !== 1'b1 && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        check(0, "b2b first latency", edges, 5);
        check(0, "b2b first sout", sout_v[0], 16'h000F);
        check(0, "b2b first carry", carry_v[0], 0);
        in_v[0] = 16'h8001; mode_v[0] = 3'd4; amt_v[0] = 4'd1;
        @(negedge clk);
        start_v[0] = 1'b0;
        check(0, "b2b no idle gap", busy_v[0], 1);
        check(0, "b2b done dropped", done_v[0], 0);
        edges = 1;
        while (done_v[0] !== 1'b1 && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        check(0, "b2b second latency", edges, 2);
        check(0, "b2b second sout", sout_v[0], 16'h0003);
        check(0, "b2b second carry", carry_v[0], 1);
        @(negedge clk);
        check(0, "b2b single done pulse", done_v[0], 0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
